// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: the four control tokens and the alignment FSM states.
package tmds_pkg;

  localparam logic [9:0] TokC00 = 10'h354;
  localparam logic [9:0] TokC01 = 10'h0AB;
  localparam logic [9:0] TokC10 = 10'h154;
  localparam logic [9:0] TokC11 = 10'h2AB;

  typedef enum logic [1:0] {
    StHunt,
    StSlip,
    StLocked
  } state_e;

endpackage

// File: rtl/tmds_sym_decode.sv
// Combinational TMDS symbol decode: control-token detect plus 8b data recovery.
module tmds_sym_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic       is_ctrl_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  logic [7:0] t;

  always_comb begin
    is_ctrl_o = 1'b1;
    ctrl_o    = 2'b00;
    unique case (sym_i)
      TokC00:  ctrl_o = 2'b00;
      TokC01:  ctrl_o = 2'b01;
      TokC10:  ctrl_o = 2'b10;
      TokC11:  ctrl_o = 2'b11;
      default: is_ctrl_o = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR chain selected by bit 8.
  always_comb begin
    t         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = 8'h00;
    data_o[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// TMDS receive channel: word alignment FSM with bitslip requests and a 2-stage decode pipeline.
// Define TMDS_RX_ERRCNT_EN to add the oLOSS_CNT lock-loss counter.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN    = 8,
  parameter int unsigned SEARCH_LEN  = 1024,
  parameter int unsigned SLIP_WAIT   = 16,
  parameter int unsigned LOSS_WINDOW = 2048
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [9:0]  iSYM,
  output logic [7:0]  oDATA,
  output logic        oDE,
  output logic [1:0]  oCTRL,
  output logic        oBITSLIP,
`ifdef TMDS_RX_ERRCNT_EN
  output logic        oLOCKED,
  output logic [15:0] oLOSS_CNT
`else
  output logic        oLOCKED
`endif
);

  localparam int unsigned TmrMax0 = (SEARCH_LEN > LOSS_WINDOW) ? SEARCH_LEN : LOSS_WINDOW;
  localparam int unsigned TmrMax  = (TmrMax0 > SLIP_WAIT) ? TmrMax0 : SLIP_WAIT;
  localparam int unsigned TmrW    = $clog2(TmrMax + 1);
  localparam int unsigned RunW    = $clog2(CTRL_RUN + 1);

  logic            dec_ctrl;
  logic [1:0]      dec_cval;
  logic [7:0]      dec_data;
  logic            s1_ctrl_q;
  logic [1:0]      s1_cval_q;
  logic [7:0]      s1_data_q;
  logic [RunW-1:0] run_q, run_d;
  logic            run_done;
  state_e          state_q;
  logic [TmrW-1:0] tmr_q;
  logic            bitslip_q, locked_q, de_q;
  logic [7:0]      data_q;
  logic [1:0]      ctrl_q;
`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0]     loss_q;
  assign oLOSS_CNT = loss_q;
`endif

  tmds_sym_decode u_dec (
    .sym_i     (iSYM),
    .is_ctrl_o (dec_ctrl),
    .ctrl_o    (dec_cval),
    .data_o    (dec_data)
  );

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      s1_ctrl_q <= 1'b0;
      s1_cval_q <= 2'b00;
      s1_data_q <= 8'h00;
      de_q      <= 1'b0;
      data_q    <= 8'h00;
      ctrl_q    <= 2'b00;
    end else begin
      s1_ctrl_q <= dec_ctrl;
      s1_cval_q <= dec_cval;
      s1_data_q <= dec_data;
      de_q      <= ~s1_ctrl_q & (state_q == StLocked);
      data_q    <= (~s1_ctrl_q & (state_q == StLocked)) ? s1_data_q : 8'h00;
      if (s1_ctrl_q) ctrl_q <= s1_cval_q;
    end
  end

  // Run of consecutive control tokens, counted on the first pipeline stage.
  always_comb begin
    run_d = run_q;
    if (state_q == StSlip || !s1_ctrl_q) begin
      run_d = '0;
    end else if (run_q != RunW'(CTRL_RUN)) begin
      run_d = run_q + RunW'(1);
    end
  end

  assign run_done = (run_d == RunW'(CTRL_RUN));

  always_ff @(posedge iCLK) begin
    if (iRESET) run_q <= '0;
    else        run_q <= run_d;
  end

  // One timer serves the search, slip-settle and loss windows; the states never overlap.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= StHunt;
      tmr_q     <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
`ifdef TMDS_RX_ERRCNT_EN
      loss_q    <= 16'h0000;
`endif
    end else begin
      bitslip_q <= 1'b0;
      locked_q  <= (state_q == StLocked);
      unique case (state_q)
        StHunt: begin
          if (run_done) begin
            state_q <= StLocked;
            tmr_q   <= '0;
          end else if (tmr_q == TmrW'(SEARCH_LEN - 1)) begin
            state_q   <= StSlip;
            tmr_q     <= '0;
            bitslip_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StSlip: begin
          if (tmr_q == TmrW'(SLIP_WAIT - 1)) begin
            state_q <= StHunt;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StLocked: begin
          if (run_done) begin
            tmr_q <= '0;
          end else if (tmr_q == TmrW'(LOSS_WINDOW - 1)) begin
            state_q <= StHunt;
            tmr_q   <= '0;
`ifdef TMDS_RX_ERRCNT_EN
            if (loss_q != 16'hFFFF) loss_q <= loss_q + 16'd1;
`endif
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        default: begin
          state_q <= StHunt;
          tmr_q   <= '0;
        end
      endcase
    end
  end

  assign oDATA    = data_q;
  assign oDE      = de_q;
  assign oCTRL    = ctrl_q;
  assign oBITSLIP = bitslip_q;
  assign oLOCKED  = locked_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Scoreboard bench for tmds_rx_decoder: directed symbols with hand-encoded expected bytes.
module tb_tmds_rx_decoder;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b1;
  logic [9:0]  iSYM = 10'h000;
  logic [7:0]  oDATA;
  logic        oDE;
  logic [1:0]  oCTRL;
  logic        oBITSLIP;
  logic        oLOCKED;
`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0] oLOSS_CNT;
`endif

  tmds_rx_decoder dut (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .iSYM      (iSYM),
    .oDATA     (oDATA),
    .oDE       (oDE),
    .oCTRL     (oCTRL),
    .oBITSLIP  (oBITSLIP),
`ifdef TMDS_RX_ERRCNT_EN
    .oLOCKED   (oLOCKED),
    .oLOSS_CNT (oLOSS_CNT)
`else
    .oLOCKED   (oLOCKED)
`endif
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  // Hand-encoded data symbols and the bytes they must decode to.
  logic [9:0] vsym [6] = '{10'h1FF, 10'h163, 10'h39C, 10'h1F0, 10'h0FF, 10'h000};
  logic [7:0] vbyte[6] = '{8'h01,   8'hA5,   8'hA5,   8'h10,   8'hFF,   8'hFE};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [9:0] s, input bit de, input logic [7:0] b);
    exp_t e;
    iSYM = s;
    if (de) begin
      e.data = b;
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRESET = 1'b1;
    repeat (3) send(10'h000, 1'b0, 8'h00);
    iRESET = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"},    32'(oDATA),    32'h0);
    chk({tag, "_de"},      32'(oDE),      32'h0);
    chk({tag, "_ctrl"},    32'(oCTRL),    32'h0);
    chk({tag, "_bitslip"}, 32'(oBITSLIP), 32'h0);
    chk({tag, "_locked"},  32'(oLOCKED),  32'h0);
`ifdef TMDS_RX_ERRCNT_EN
    chk({tag, "_loss"},    32'(oLOSS_CNT), 32'h0);
`endif
  endtask

  // Monitor: every oDE beat must match the oldest expectation, on its due cycle.
  always @(negedge iCLK) begin
    exp_t e;
    if (oDE) begin
      nchk++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL de_unexpected: got data %02h with oDE=1, expected oDE=0 (cyc %0d)",
                 oDATA, cyc);
      end else begin
        e = sb.pop_front();
        if (oDATA !== e.data || cyc != e.due) begin
          nerr++;
          $display("FAIL de_data: got %02h at cyc %0d, expected %02h at cyc %0d",
                   oDATA, cyc, e.data, e.due);
        end
      end
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        nchk++;
        nerr++;
        $display("FAIL de_missing: got oDE=0 at cyc %0d, expected %02h due %0d",
                 cyc, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
      if (!iRESET) begin
        nchk++;
        if (oDATA !== 8'h00) begin
          nerr++;
          $display("FAIL idle_data: got %02h expected 00 (cyc %0d)", oDATA, cyc);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge iCLK);
    #1;
    // Reset values
    do_reset();
    chk_reset_outs("rst");

    // Lock on C10 tokens, oCTRL latency, data decode and oDE
    send(tmds_pkg::TokC10, 1'b0, 8'h00);
    chk("ctrl_lat1", 32'(oCTRL), 32'h0);
    send(tmds_pkg::TokC10, 1'b0, 8'h00);
    chk("ctrl_lat2", 32'(oCTRL), 32'h2);
    repeat (6) send(tmds_pkg::TokC10, 1'b0, 8'h00);
    chk("lock_pre", 32'(oLOCKED), 32'h0);
    send(vsym[0], 1'b1, vbyte[0]);
    chk("lock_early", 32'(oLOCKED), 32'h0);
    send(vsym[1], 1'b1, vbyte[1]);
    chk("lock_set", 32'(oLOCKED), 32'h1);
    for (int i = 2; i < 6; i++) send(vsym[i], 1'b1, vbyte[i]);
    chk("ctrl_hold", 32'(oCTRL), 32'h2);
    send(tmds_pkg::TokC11, 1'b0, 8'h00);
    send(tmds_pkg::TokC11, 1'b0, 8'h00);
    chk("ctrl_c11", 32'(oCTRL), 32'h3);
    chk("de_on_token", 32'(oDE), 32'h0);

    // Broken run must not lock; a full run must
    do_reset();
    chk("rst_ctrl_clear", 32'(oCTRL), 32'h0);
    repeat (7) send(tmds_pkg::TokC01, 1'b0, 8'h00);
    send(10'h000, 1'b0, 8'h00);
    repeat (7) send(tmds_pkg::TokC01, 1'b0, 8'h00);
    send(10'h000, 1'b0, 8'h00);
    send(10'h000, 1'b0, 8'h00);
    chk("run_broken", 32'(oLOCKED), 32'h0);
    repeat (8) send(tmds_pkg::TokC01, 1'b0, 8'h00);
    send(vsym[3], 1'b1, vbyte[3]);
    send(vsym[1], 1'b1, vbyte[1]);
    chk("run_full", 32'(oLOCKED), 32'h1);
    chk("ctrl_c01", 32'(oCTRL), 32'h1);
    repeat (2) send(tmds_pkg::TokC01, 1'b0, 8'h00);

    // Loss of lock after 2048 data-only cycles
    do_reset();
    repeat (8) send(tmds_pkg::TokC00, 1'b0, 8'h00);
    for (int i = 0; i < 2048; i++) send(vsym[i % 6], 1'b1, vbyte[i % 6]);
    chk("loss_hold0", 32'(oLOCKED), 32'h1);
    send(vsym[1], 1'b0, 8'h00);
    chk("loss_hold1", 32'(oLOCKED), 32'h1);
    send(vsym[1], 1'b0, 8'h00);
    chk("loss_drop", 32'(oLOCKED), 32'h0);
    chk("loss_de", 32'(oDE), 32'h0);
    chk("loss_data", 32'(oDATA), 32'h0);
`ifdef TMDS_RX_ERRCNT_EN
    chk("loss_cnt", 32'(oLOSS_CNT), 32'h1);
`endif

    // Misaligned stream: bitslip cadence
    do_reset();
    for (int n = 1; n <= 2070; n++) begin
      send(10'h2A9, 1'b0, 8'h00);
      if (n == 1024 || n == 2064 || (n % 100) == 0 || n == 1025 || n == 2065)
        chk("bitslip_cadence", 32'(oBITSLIP), 32'(n == 1024 || n == 2064));
      else if (oBITSLIP !== 1'b0)
        chk("bitslip_spurious", 32'(oBITSLIP), 32'h0);
    end
    chk("slip_nolock", 32'(oLOCKED), 32'h0);

    // Stream realigned after the first bitslip locks
    do_reset();
    for (int n = 1; n <= 1024; n++) send(10'h2A9, 1'b0, 8'h00);
    chk("realign_slip", 32'(oBITSLIP), 32'h1);
    for (int n = 1025; n <= 1048; n++) send(tmds_pkg::TokC00, 1'b0, 8'h00);
    chk("realign_pre", 32'(oLOCKED), 32'h0);
    send(tmds_pkg::TokC00, 1'b0, 8'h00);
    chk("realign_lock", 32'(oLOCKED), 32'h1);

    // Reset on the first SLIP cycle aborts cleanly
    do_reset();
    for (int n = 1; n <= 1024; n++) send(10'h2A9, 1'b0, 8'h00);
    chk("abort_slip", 32'(oBITSLIP), 32'h1);
    iRESET = 1'b1;
    send(10'h2A9, 1'b0, 8'h00);
    chk_reset_outs("abort");
    iRESET = 1'b0;
    for (int n = 0; n < 40; n++) begin
      send(10'h2A9, 1'b0, 8'h00);
      if (oBITSLIP !== 1'b0 || n == 39) chk("abort_noslip", 32'(oBITSLIP), 32'h0);
    end

    repeat (3) send(10'h000, 1'b0, 8'h00);
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
